// File: rtl/ad9364_tx_scheduler.sv
// Paced two-source transmit scheduler for the AD9364 1R1T DAC port.
// Each grant covers a fixed-length burst; strobes no source fills carry an idle sample.
module ad9364_tx_scheduler #(
    parameter int            DW        = 12,
    parameter int            RATE_DIV  = 2,
    parameter int            BURST_LEN = 16,
    parameter logic [DW-1:0] IDLE_I    = '0,
    parameter logic [DW-1:0] IDLE_Q    = '0
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          enable,
    input  logic          prio_mode,
    input  logic          underflow_clr,
    input  logic          s0_valid,
    input  logic [DW-1:0] s0_data_i,
    input  logic [DW-1:0] s0_data_q,
    output logic          s0_ready,
    input  logic          s1_valid,
    input  logic [DW-1:0] s1_data_i,
    input  logic [DW-1:0] s1_data_q,
    output logic          s1_ready,
    output logic          dac_valid,
    output logic [DW-1:0] dac_data_i1,
    output logic [DW-1:0] dac_data_q1,
    output logic [1:0]    grant,
    output logic          underflow,
    output logic [15:0]   underflow_cnt
);

    typedef enum logic {ST_IDLE, ST_STREAM} state_t;

    localparam logic [3:0]  PACE_LAST  = 4'(RATE_DIV - 1);
    localparam logic [15:0] BURST_LAST = 16'(BURST_LEN - 1);

    state_t        state, state_nxt;
    logic [3:0]    pace_cnt;
    logic [15:0]   burst_cnt, burst_nxt;
    logic [1:0]    grant_nxt, pick;
    logic          last_grant, last_nxt;
    logic          tick, sel_valid, take, send_idle, uf_evt;
    logic [DW-1:0] sel_i, sel_q;

    assign tick      = enable && (pace_cnt == PACE_LAST);
    assign sel_valid = grant[1] ? s1_valid  : s0_valid;
    assign sel_i     = grant[1] ? s1_data_i : s0_data_i;
    assign sel_q     = grant[1] ? s1_data_q : s0_data_q;
    assign s0_ready  = (state == ST_STREAM) && tick && grant[0];
    assign s1_ready  = (state == ST_STREAM) && tick && grant[1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            pace_cnt <= '0;
        else if (!enable || pace_cnt == PACE_LAST)
            pace_cnt <= '0;
        else
            pace_cnt <= pace_cnt + 4'd1;
    end

    // last_grant=1 means s1 was served last, so s0 wins the next contested round.
    always_comb begin
        pick = 2'b10;
        if (s0_valid && s1_valid)
            pick = (prio_mode || last_grant) ? 2'b01 : 2'b10;
        else if (s0_valid)
            pick = 2'b01;
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        last_nxt  = last_grant;
        burst_nxt = burst_cnt;
        take      = 1'b0;
        send_idle = 1'b0;
        uf_evt    = 1'b0;
        if (!enable) begin
            state_nxt = ST_IDLE;
            grant_nxt = 2'b00;
            burst_nxt = '0;
            if (grant != 2'b00)
                last_nxt = grant[1];
        end else begin
            case (state)
                ST_IDLE: begin
                    send_idle = tick;
                    if (s0_valid || s1_valid) begin
                        grant_nxt = pick;
                        state_nxt = ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (tick) begin
                        if (sel_valid) begin
                            take = 1'b1;
                            burst_nxt = burst_cnt + 16'd1;
                        end else begin
                            send_idle = 1'b1;
                            uf_evt    = 1'b1;
                        end
                        if (!sel_valid || burst_cnt == BURST_LAST) begin
                            state_nxt = ST_IDLE;
                            grant_nxt = 2'b00;
                            last_nxt  = grant[1];
                            burst_nxt = '0;
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= ST_IDLE;
            grant         <= 2'b00;
            last_grant    <= 1'b1;
            burst_cnt     <= '0;
            dac_valid     <= 1'b0;
            dac_data_i1   <= '0;
            dac_data_q1   <= '0;
            underflow     <= 1'b0;
            underflow_cnt <= '0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_nxt;
            burst_cnt  <= burst_nxt;
            dac_valid  <= take || send_idle;
            underflow  <= uf_evt;
            if (take) begin
                dac_data_i1 <= sel_i;
                dac_data_q1 <= sel_q;
            end else if (send_idle) begin
                dac_data_i1 <= IDLE_I;
                dac_data_q1 <= IDLE_Q;
            end
            // A clear in the same cycle as an underflow leaves the count at zero.
            if (underflow_clr)
                underflow_cnt <= '0;
            else if (uf_evt && underflow_cnt != 16'hFFFF)
                underflow_cnt <= underflow_cnt + 16'd1;
        end
    end

endmodule
